// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit FIFO: drain state
//               encoding, status bit positions and register offsets for AB.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Drain state machine encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } drain_state_t;

    // Status register bit positions
    localparam int c_stat_full  = 0;
    localparam int c_stat_empty = 1;
    localparam int c_stat_busy  = 2;
    localparam int c_stat_ovf   = 3;

    // Register offsets selected by AB
    localparam logic c_reg_data = 1'b0;
    localparam logic c_reg_ctrl = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : FIFO storage with its own write/read pointers. Synchronous
//               write port, asynchronous read of the entry at the read pointer.
//               Pointers wrap naturally at DEPTH (power of two).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);
    import uart_pkg::*;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;

    // Advance pointers on push/pop; reset discards contents by rewinding both
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage array is not reset; only the pointers define valid contents
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO between the 6502 bus and the UART transmitter.
//               CPU data writes are queued; a drain FSM hands one byte at a
//               time to the transmitter via a level tx_start / tx_busy
//               handshake, with a timeout if tx_busy never rises.
//               Optional macro UART_TXF_OVERFLOW_EN adds a sticky overflow
//               flag (status bit 3) set by a write into a full FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int BUSY_TIMEOUT = 1024,
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CS,
    input  logic          WE,
    input  logic          AB,
    input  logic [7:0]    DI,
    output logic [7:0]    DO,
    input  logic          tx_busy,
    output logic [7:0]    tx_byte,
    output logic          tx_start,
    output logic [LW-1:0] level
);

    localparam int            CW             = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [LW-1:0] c_level_full   = LW'(DEPTH);
    localparam logic [CW-1:0] c_timeout_last = CW'(BUSY_TIMEOUT - 1);

    logic          w_acc;
    logic          r_acc_q;
    logic          w_acc_rise;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_overflow;
    logic          w_tx_start;
    logic [7:0]    w_rd_data;
    logic [7:0]    w_status;
    logic [7:0]    r_do;
    logic [7:0]    r_tx_byte;
    logic [LW-1:0] r_level;
    logic [CW-1:0] r_wait_cnt;
    drain_state_t  r_state;
    drain_state_t  w_state_nxt;

    // ------------------------------------------------------------------
    // Bus access detection: one action per write access, however long CS
    // stays asserted.
    // ------------------------------------------------------------------
    assign w_acc      = CS & WE;
    assign w_acc_rise = w_acc & ~r_acc_q;

    // Registered copy of the write-access strobe for edge detection
    always_ff @(posedge clk) begin
        if (rst) r_acc_q <= 1'b0;
        else     r_acc_q <= w_acc;
    end

    assign w_full  = (r_level == c_level_full);
    assign w_empty = (r_level == '0);
    assign w_push  = w_acc_rise & (AB == c_reg_data) & ~w_full;

`ifdef UART_TXF_OVERFLOW_EN
    logic w_drop;
    logic w_ovf_clr;
    logic r_overflow;

    assign w_drop    = w_acc_rise & (AB == c_reg_data) & w_full;
    assign w_ovf_clr = w_acc_rise & (AB == c_reg_ctrl) & DI[0];

    // Sticky overflow flag: set by a dropped byte, cleared by control write
    always_ff @(posedge clk) begin
        if (rst)            r_overflow <= 1'b0;
        else if (w_ovf_clr) r_overflow <= 1'b0;
        else if (w_drop)    r_overflow <= 1'b1;
    end

    assign w_overflow = r_overflow;
`else
    assign w_overflow = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (DI),
        .rd_data (w_rd_data)
    );

    // Occupancy count; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status and CPU read path
    // ------------------------------------------------------------------
    // Assemble the status byte from the live flags
    always_comb begin
        w_status              = 8'h00;
        w_status[c_stat_full]  = w_full;
        w_status[c_stat_empty] = w_empty;
        w_status[c_stat_busy]  = tx_busy;
        w_status[c_stat_ovf]   = w_overflow;
    end

    // Read data is registered every cycle; data offset reads back as zero
    always_ff @(posedge clk) begin
        if (rst)                    r_do <= 8'h00;
        else if (AB == c_reg_ctrl)  r_do <= w_status;
        else                        r_do <= 8'h00;
    end

    assign DO = (CS & ~WE) ? r_do : 8'bz;

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (~w_empty & ~tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_tx_start = 1'b1;
                if (tx_busy)
                    w_state_nxt = SEND;
                else if (r_wait_cnt == c_timeout_last)
                    w_state_nxt = IDLE;
            end
            SEND: begin
                if (~tx_busy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Byte latch and busy-timeout counter, both restarted on each pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_byte  <= 8'h00;
            r_wait_cnt <= '0;
        end else if (w_pop) begin
            r_tx_byte  <= w_rd_data;
            r_wait_cnt <= '0;
        end else if (r_state == START) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    assign tx_start = w_tx_start;
    assign tx_byte  = r_tx_byte;
    assign level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A queue-based model of
//               the FIFO and hand-off protocol is compared against the DUT on
//               every negative clock edge; directed scenarios add literal
//               expectations, followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int BT    = 24;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TXF_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          CS  = 1'b0;
    logic          WE  = 1'b0;
    logic          AB  = 1'b0;
    logic [7:0]    DI  = 8'h00;
    wire  [7:0]    DO;
    logic          tx_busy = 1'b0;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .CS       (CS),
        .WE       (WE),
        .AB       (AB),
        .DI       (DI),
        .DO       (DO),
        .tx_busy  (tx_busy),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .level    (level)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte queue plus who currently owns the head byte
    //   owner 0: nothing handed over, 1: offered to transmitter,
    //   owner 2: transmitter has accepted it
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    int         m_owner = 0;
    int         m_wait  = 0;
    logic [7:0] m_byte  = 8'h00;
    logic       m_ovf   = 1'b0;
    logic       m_prev_acc = 1'b0;
    logic [7:0] m_do    = 8'h00;
    bit         chk_en  = 1'b0;
    int         pre_n;
    bit         rise;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_owner    = 0;
            m_wait     = 0;
            m_byte     = 8'h00;
            m_ovf      = 1'b0;
            m_prev_acc = 1'b0;
            m_do       = 8'h00;
        end else begin
            pre_n      = m_q.size();
            rise       = CS && WE && !m_prev_acc;
            m_prev_acc = CS && WE;
            m_do = AB ? {4'b0000, m_ovf, tx_busy, (pre_n == 0), (pre_n == DEPTH)} : 8'h00;
            if (m_owner == 0) begin
                if (pre_n > 0 && !tx_busy) begin
                    m_byte  = m_q.pop_front();
                    m_owner = 1;
                    m_wait  = 0;
                end
            end else if (m_owner == 1) begin
                if (tx_busy)               m_owner = 2;
                else if (m_wait == BT - 1) m_owner = 0;
                else                       m_wait++;
            end else begin
                if (!tx_busy) m_owner = 0;
            end
            if (rise && !AB) begin
                if (pre_n < DEPTH) m_q.push_back(DI);
                else if (OVF_EN)   m_ovf = 1'b1;
            end
            if (rise && AB && DI[0]) m_ovf = 1'b0;
        end
        chk_en = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", level, m_q.size());
            chk("tx_start", tx_start, (m_owner == 1));
            chk("tx_byte", tx_byte, m_byte);
            if (CS && !WE) chk("DO", DO, m_do);
        end
    end

    // Monitor: record bytes at each tx_start rise, track peak level
    int         n_rises = 0;
    int         peak    = 0;
    logic       mon_prev = 1'b0;
    logic [7:0] dut_bytes[$];

    always @(negedge clk) begin
        if (tx_start && !mon_prev) begin
            n_rises++;
            dut_bytes.push_back(tx_byte);
        end
        mon_prev = tx_start;
        if (int'(level) > peak) peak = int'(level);
    end

    // ------------------------------------------------------------------
    // Transmitter stand-in
    //   0: follow busy_req, 1: busy 3 cycles after start for 100 cycles,
    //   2: never busy, 3: random toggling
    // ------------------------------------------------------------------
    int   xmode    = 0;
    bit   busy_req = 1'b0;
    int   x_dly    = 0;
    int   x_hold   = 0;
    logic x_prev   = 1'b0;

    always @(posedge clk) begin
        #3;
        case (xmode)
            0: begin
                tx_busy = busy_req;
                x_dly = 0; x_hold = 0;
            end
            1: begin
                if (x_hold > 0) begin
                    x_hold--;
                    if (x_hold == 0) tx_busy = 1'b0;
                end else if (x_dly > 0) begin
                    x_dly++;
                    if (x_dly == 3) begin
                        tx_busy = 1'b1;
                        x_hold  = 100;
                        x_dly   = 0;
                    end
                end else if (tx_start && !x_prev) begin
                    x_dly = 1;
                end
            end
            2: begin
                tx_busy = 1'b0;
                x_dly = 0; x_hold = 0;
            end
            default: begin
                if ($urandom_range(0, 7) == 0) tx_busy = ~tx_busy;
                x_dly = 0; x_hold = 0;
            end
        endcase
        x_prev = tx_start;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic ab, input logic [7:0] d, input int hold);
        CS = 1'b1; WE = 1'b1; AB = ab; DI = d;
        repeat (hold) tick();
        CS = 1'b0; WE = 1'b0;
        tick();
    endtask

    task automatic read_status(output logic [7:0] val);
        CS = 1'b1; WE = 1'b0; AB = 1'b1;
        tick();
        val = DO;
        CS = 1'b0; AB = 1'b0;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] v;
    int         w;
    int         len;
    int         r;

    initial begin
        // ---------------- reset ----------------
        repeat (3) tick();
        chk("rst_level", level, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        rst = 1'b0;
        tick();
        read_status(v);
        chk("rst_status", v, 8'h02);

        // ---------------- three bytes, transmitter idle ----------------
        n_rises = 0; peak = 0; dut_bytes.delete();
        bus_write(1'b0, 8'h41, 1);
        bus_write(1'b0, 8'h42, 1);
        bus_write(1'b0, 8'h43, 1);
        repeat (3 * (BT + 2) + 10) tick();
        chk("t1_rises", n_rises, 3);
        chk("t1_byte0", (dut_bytes.size() > 0) ? dut_bytes[0] : 8'hxx, 8'h41);
        chk("t1_byte1", (dut_bytes.size() > 1) ? dut_bytes[1] : 8'hxx, 8'h42);
        chk("t1_byte2", (dut_bytes.size() > 2) ? dut_bytes[2] : 8'hxx, 8'h43);
        chk("t1_peak_in_range", (peak >= 1 && peak <= 3), 1);

        // ---------------- responsive transmitter ----------------
        xmode = 1; n_rises = 0;
        bus_write(1'b0, 8'h51, 1);
        bus_write(1'b0, 8'h52, 1);
        bus_write(1'b0, 8'h53, 1);
        w = 0;
        while ((m_q.size() > 0 || m_owner != 0 || tx_busy) && w < 600) begin
            tick(); w++;
        end
        chk("t2_drained", (w < 600), 1);
        chk("t2_rises", n_rises, 3);

        // ---------------- fill and overflow ----------------
        xmode = 0; busy_req = 1'b1;
        tick(); tick();
        for (int i = 0; i < 16; i++) bus_write(1'b0, 8'(8'h60 + i), 1);
        bus_write(1'b0, 8'hFF, 1);
        chk("t3_level_full", level, 16);
        read_status(v);
        chk("t3_status_full", v, OVF_EN ? 8'h0D : 8'h05);
        bus_write(1'b1, 8'h01, 3);
        read_status(v);
        chk("t3_status_clr", v, 8'h05);
        chk("t3_level_kept", level, 16);

        // ---------------- busy never rises: timeouts ----------------
        n_rises = 0; dut_bytes.delete();
        xmode = 2;
        for (int b = 0; b < 16; b++) begin
            w = 0;
            while (!tx_start && w < 2 * BT) begin tick(); w++; end
            chk("t4_launch", tx_start, 1);
            if (b > 0) chk("t4_gap", w, 1);
            len = 0;
            while (tx_start && len < 2 * BT) begin tick(); len++; end
            chk("t4_start_len", len, BT);
        end
        chk("t4_rises", n_rises, 16);
        for (int b = 0; b < 16; b++)
            chk("t4_order", (dut_bytes.size() > b) ? dut_bytes[b] : 8'hxx, 8'(8'h60 + b));

        // ---------------- reset while transmitter owns a byte ----------------
        xmode = 1;
        tick();
        for (int i = 0; i < 6; i++) bus_write(1'b0, 8'(8'h70 + i), 1);
        w = 0;
        while (m_owner != 2 && w < 200) begin tick(); w++; end
        chk("t5_in_send", m_owner, 2);
        chk("t5_level5", level, 5);
        rst = 1'b1;
        tick();
        chk("t5_rst_level", level, 0);
        chk("t5_rst_tx_start", tx_start, 0);
        rst = 1'b0;
        w = 0;
        while (tx_busy && w < 200) begin tick(); w++; end
        chk("t5_busy_fell", tx_busy, 0);
        read_status(v);
        chk("t5_status", v, 8'h02);

        // ---------------- randomized traffic ----------------
        xmode = 3;
        for (int it = 0; it < 2500; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                bus_write(1'b0, 8'($urandom), int'($urandom_range(1, 3)));
            end else if (r < 48) begin
                bus_write(1'b1, 8'($urandom), 1);
            end else if (r < 68) begin
                CS = 1'b1; WE = 1'b0; AB = 1'($urandom);
                repeat (int'($urandom_range(1, 3))) tick();
                CS = 1'b0;
                tick();
            end else if (r == 68 && $urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        xmode = 0; busy_req = 1'b0;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
